qsysdemo_sw_debounce: RTL and testbench
=======================================

Name: qsysdemo_sw_debounce

Overview:
Conditions the board's 18 raw slide-switch inputs before they reach the switch PIO's in_port.
- Synchronises each bit into the system clock domain.
- Debounces each bit independently with a per-bit stability counter.
- Emits a one-cycle change strobe per bit when a debounced value flips.
- Sits between the top-level switch pins and the switch PIO inside the Qsys system.

Parameters:
- WIDTH, 18: number of switch bits.
- SYNC_STAGES, 2: synchroniser flops per bit; legal range 2..4.
- DEBOUNCE_CYCLES, 500000: consecutive cycles a synchronised bit must differ from its stable value before it is accepted (10 ms at 50 MHz); must be ≥1.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- sw_raw, in, WIDTH: asynchronous switch pins.
- sw_stable, out, WIDTH: debounced switch value; drives the PIO in_port.
- sw_changed, out, WIDTH: one-cycle pulse per bit on each sw_stable transition.
- any_change, out, 1: OR-reduction of sw_changed, same cycle.

Behaviour:
- Reset, sampled on the rising edge of clk while high:
  - All synchroniser flops, sw_stable, counters, sw_changed and any_change clear to 0.
  - Reset asserted mid-count discards the count; no pulse is generated.
- Synchroniser:
  - sw_raw passes through a SYNC_STAGES flop chain per bit; sync[i] is the last stage.
  - No logic between stages.
- Counter width: CW = max(1, $clog2(DEBOUNCE_CYCLES)).
- Per-bit rules at each edge (bit i, counter cnt[i]):
  - sync[i] == sw_stable[i]: cnt[i] ← 0, sw_changed[i] ← 0.
  - sync[i] != sw_stable[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] ← cnt[i]+1, sw_changed[i] ← 0.
  - sync[i] != sw_stable[i] and cnt[i] == DEBOUNCE_CYCLES-1: sw_stable[i] ← sync[i], cnt[i] ← 0, sw_changed[i] ← 1.
- Glitch rejection: any bounce returning sync[i] to sw_stable[i] before acceptance restarts the count from 0.
- Latency: a raw level held steady appears on sw_stable exactly SYNC_STAGES+DEBOUNCE_CYCLES cycles after the first clk edge that samples it.
- Bits are fully independent. Simultaneous flips of several bits give simultaneous pulses, and any_change pulses once.
- Counters never wrap: the maximum reached is DEBOUNCE_CYCLES-1.
- Power-up: switches that are high at reset release read 0 first, then flip to 1 with a sw_changed pulse after the full latency. This is intended.
- All outputs are registered, except any_change, which is combinational from registered sw_changed.

Optional Feature:
Macro: SW_DEBOUNCE_EDGE_CAPTURE_EN.
- When defined, adds two ports:
  - edge_clear, in, WIDTH.
  - edge_capture, out, WIDTH, reset value 0.
- Per-bit edge_capture rules:
  - Bit i sets on sw_changed[i] and stays set until edge_clear[i] is sampled high.
  - If set and clear occur in the same cycle, set wins.
- When undefined, neither port exists and no capture logic is generated.

Decomposition:
- Package qsysdemo_sw_pkg holds:
  - Default constants SW_WIDTH=18 and SW_DEBOUNCE_CYCLES_50MHZ=500000.
  - A helper function for counter width.
- Sub-module sw_debounce_bit: single-bit synchroniser plus counter plus pulse. Parameterised by SYNC_STAGES and DEBOUNCE_CYCLES.
- The top module instantiates WIDTH copies in a generate loop and ORs their pulses.

Test Plan:
All scenarios use the bench parameters SYNC_STAGES=2, DEBOUNCE_CYCLES=4, WIDTH=18.
1. Reset with sw_raw=0x3FFFF held → sw_stable=0 during reset. After release, sw_stable=0x3FFFF exactly 6 cycles later, sw_changed=0x3FFFF for 1 cycle, any_change=1 for 1 cycle.
2. Steady 0, set sw_raw[0]=1 permanently → sw_stable[0] rises at cycle 6, sw_changed[0] pulses once, other bits stay 0.
3. Bounce bit 5: raw 1 for 3 cycles, 0 for 1, 1 for 3, 0 thereafter → sw_stable[5] never changes, no pulse.
4. Bits 3 and 17 flip on the same edge and hold → both stable bits update on the same cycle, any_change high for exactly 1 cycle.
5. Assert reset for 1 cycle at count 2 of a pending flip → no pulse. The flip completes 6 cycles after reset release if raw is still held.
6. With SW_DEBOUNCE_EDGE_CAPTURE_EN defined:
   - A pulse on bit 7 sets edge_capture=0x00080; it holds until edge_clear[7]=1 clears it the next cycle.
   - edge_clear[7] asserted on the same cycle as a pulse leaves edge_capture[7]=1.

Source files
------------

// File: rtl/qsysdemo_sw_pkg.sv
// Shared constants and helpers for the slide-switch debouncer.
package qsysdemo_sw_pkg;

   localparam int unsigned SW_WIDTH                 = 18;
   localparam int unsigned SW_DEBOUNCE_CYCLES_50MHZ = 500000;

   // Counter must hold DEBOUNCE_CYCLES-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      int unsigned w;
      w = $clog2(cycles);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// Single switch bit: synchroniser chain, stability counter and change pulse.
module sw_debounce_bit
   import qsysdemo_sw_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_50MHZ
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic raw_i,
   output logic stable_o,
   output logic changed_o
);

   localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   stable_q, stable_d;
   logic                   changed_q, changed_d;

   assign sync = sync_q[SYNC_STAGES-1];

   always_comb begin
      cnt_d     = '0;
      stable_d  = stable_q;
      changed_d = 1'b0;
      if (sync != stable_q) begin
         if (cnt_q == CntMax) begin
            stable_d  = sync;
            changed_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync_q    <= '0;
         cnt_q     <= '0;
         stable_q  <= 1'b0;
         changed_q <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], raw_i};
         cnt_q     <= cnt_d;
         stable_q  <= stable_d;
         changed_q <= changed_d;
      end
   end

   assign stable_o  = stable_q;
   assign changed_o = changed_q;

endmodule

// File: rtl/qsysdemo_sw_debounce.sv
// Debounces the raw slide switches ahead of the switch PIO in_port.
// Define SW_DEBOUNCE_EDGE_CAPTURE_EN to add sticky edge_capture/edge_clear.
module qsysdemo_sw_debounce
   import qsysdemo_sw_pkg::*;
#(
   parameter int unsigned WIDTH           = SW_WIDTH,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_50MHZ
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_stable,
   output logic [WIDTH-1:0] sw_changed,
`ifdef SW_DEBOUNCE_EDGE_CAPTURE_EN
   input  logic [WIDTH-1:0] edge_clear,
   output logic [WIDTH-1:0] edge_capture,
`endif
   output logic             any_change
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      sw_debounce_bit #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_bit (
         .clk_i     (clk),
         .reset_i   (reset),
         .raw_i     (sw_raw[i]),
         .stable_o  (sw_stable[i]),
         .changed_o (sw_changed[i])
      );
   end

   assign any_change = |sw_changed;

`ifdef SW_DEBOUNCE_EDGE_CAPTURE_EN
   logic [WIDTH-1:0] capture_q, capture_d;

   // Set has priority over clear so a same-cycle pulse is never lost.
   always_comb begin
      capture_d = (capture_q & ~edge_clear) | sw_changed;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         capture_q <= '0;
      end else begin
         capture_q <= capture_d;
      end
   end

   assign edge_capture = capture_q;
`endif

endmodule

// File: tb/tb_qsysdemo_sw_debounce.sv
// Self-checking bench for qsysdemo_sw_debounce (WIDTH=18, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
module tb_qsysdemo_sw_debounce;

   localparam int W = 18;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] sw_raw;
   logic [W-1:0] sw_stable;
   logic [W-1:0] sw_changed;
   logic         any_change;
`ifdef SW_DEBOUNCE_EDGE_CAPTURE_EN
   logic [W-1:0] edge_clear;
   logic [W-1:0] edge_capture;
`endif

   always #5 clk = ~clk;

   qsysdemo_sw_debounce #(
      .WIDTH           (W),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sw_raw       (sw_raw),
      .sw_stable    (sw_stable),
      .sw_changed   (sw_changed),
`ifdef SW_DEBOUNCE_EDGE_CAPTURE_EN
      .edge_clear   (edge_clear),
      .edge_capture (edge_capture),
`endif
      .any_change   (any_change)
   );

   typedef struct {
      logic         rst;
      logic [W-1:0] raw;
      logic [W-1:0] clr;
      int           cyc;
      logic [W-1:0] exp_stable;
      int           exp_pulses;
      logic [W-1:0] exp_cap;
   } vec_t;

   typedef struct {
      logic [W-1:0] st;
      logic [W-1:0] chg;
      logic [W-1:0] cap;
   } exp_t;

   vec_t         vecs [21];
   exp_t         sbq [$];
   logic [W-1:0] hist [6];
   logic [W-1:0] m_st, m_chg, m_cap;
   int           checks = 0;
   int           errors = 0;
   int           pulses;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Window model: a bit is accepted once its synchronised value (raw two
   // samples back) has disagreed with the stable value for 4 straight edges.
   task automatic step(input vec_t v);
      exp_t e;
      logic [W-1:0] flip;
      reset  = v.rst;
      sw_raw = v.raw;
`ifdef SW_DEBOUNCE_EDGE_CAPTURE_EN
      edge_clear = v.clr;
`endif
      @(posedge clk);
      if (v.rst) begin
         for (int k = 0; k < 6; k++) hist[k] = '0;
         m_st = '0; m_chg = '0; m_cap = '0;
      end else begin
         m_cap = (m_cap & ~v.clr) | m_chg;
         for (int k = 5; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = v.raw;
         flip = (hist[2] ^ m_st) & (hist[3] ^ m_st) & (hist[4] ^ m_st) & (hist[5] ^ m_st);
         m_st  = m_st ^ flip;
         m_chg = flip;
      end
      e.st = m_st; e.chg = m_chg; e.cap = m_cap;
      sbq.push_back(e);
      #1;
      e = sbq.pop_front();
      check("sw_stable", sw_stable, e.st);
      check("sw_changed", sw_changed, e.chg);
      check("any_change", {{(W-1){1'b0}}, any_change}, {{(W-1){1'b0}}, |e.chg});
`ifdef SW_DEBOUNCE_EDGE_CAPTURE_EN
      check("edge_capture", edge_capture, e.cap);
`endif
      if (any_change === 1'b1) pulses++;
   endtask

   initial begin
      // rst, raw, clr, cycles, expected stable, expected any_change pulses, expected capture
      vecs[0]  = '{1'b1, 18'h3FFFF, 18'h0,     3,  18'h0,     0, 18'h0};
      vecs[1]  = '{1'b0, 18'h3FFFF, 18'h0,     5,  18'h0,     0, 18'h0};
      vecs[2]  = '{1'b0, 18'h3FFFF, 18'h0,     1,  18'h3FFFF, 1, 18'h0};
      vecs[3]  = '{1'b0, 18'h3FFFF, 18'h0,     4,  18'h3FFFF, 0, 18'h3FFFF};
      vecs[4]  = '{1'b1, 18'h0,     18'h0,     2,  18'h0,     0, 18'h0};
      vecs[5]  = '{1'b0, 18'h1,     18'h0,     10, 18'h1,     1, 18'h1};
      vecs[6]  = '{1'b0, 18'h21,    18'h0,     3,  18'h1,     0, 18'h1};
      vecs[7]  = '{1'b0, 18'h1,     18'h0,     1,  18'h1,     0, 18'h1};
      vecs[8]  = '{1'b0, 18'h21,    18'h0,     3,  18'h1,     0, 18'h1};
      vecs[9]  = '{1'b0, 18'h1,     18'h0,     8,  18'h1,     0, 18'h1};
      vecs[10] = '{1'b0, 18'h20009, 18'h0,     10, 18'h20009, 1, 18'h20009};
      vecs[11] = '{1'b0, 18'h20409, 18'h0,     4,  18'h20009, 0, 18'h20009};
      vecs[12] = '{1'b1, 18'h20409, 18'h0,     1,  18'h0,     0, 18'h0};
      vecs[13] = '{1'b0, 18'h20409, 18'h0,     10, 18'h20409, 1, 18'h20409};
      vecs[14] = '{1'b0, 18'h20409, 18'h3FFFF, 1,  18'h20409, 0, 18'h0};
      vecs[15] = '{1'b0, 18'h20489, 18'h0,     6,  18'h20489, 1, 18'h0};
      vecs[16] = '{1'b0, 18'h20489, 18'h0,     3,  18'h20489, 0, 18'h80};
      vecs[17] = '{1'b0, 18'h20489, 18'h80,    1,  18'h20489, 0, 18'h0};
      vecs[18] = '{1'b0, 18'h20409, 18'h0,     6,  18'h20409, 1, 18'h0};
      vecs[19] = '{1'b0, 18'h20409, 18'h80,    1,  18'h20409, 0, 18'h80};
      vecs[20] = '{1'b0, 18'h20409, 18'h0,     2,  18'h20409, 0, 18'h80};

      for (int k = 0; k < 6; k++) hist[k] = '0;
      m_st = '0; m_chg = '0; m_cap = '0;
      reset = 1'b1;
      sw_raw = '0;
`ifdef SW_DEBOUNCE_EDGE_CAPTURE_EN
      edge_clear = '0;
`endif

      for (int p = 0; p < 21; p++) begin
         pulses = 0;
         for (int c = 0; c < vecs[p].cyc; c++) step(vecs[p]);
         check($sformatf("phase%0d stable", p), sw_stable, vecs[p].exp_stable);
         check_int($sformatf("phase%0d pulses", p), pulses, vecs[p].exp_pulses);
`ifdef SW_DEBOUNCE_EDGE_CAPTURE_EN
         check($sformatf("phase%0d capture", p), edge_capture, vecs[p].exp_cap);
`endif
      end

      check_int("scoreboard drained", sbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
